data_rx_unstuff: RTL and testbench

DATA_RX_UNSTUFF -- requirements
Module: data_rx_unstuff

---
 rtl/data_rx_unstuff.sv | 153 +++++++++++++++
 tb/tb_data_rx_unstuff.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_rx_unstuff.sv
// data_rx_unstuff: receive path for one DATA0 packet. NRZI-decodes the line,
// removes stuff bits, collects 80 kept bits (64 payload + 16 CRC) and checks
// the length and the CRC16 residual at end of packet.
//
// Ports:
//   clock        system clock, one line bit per cycle
//   reset_n      asynchronous active-low reset
//   in_bit       raw NRZI line level (J=1, K=0)
//   dpdm_sending high while in_bit carries a payload/CRC bit
//   load_data    one-cycle end-of-packet strobe
//   data_out     received payload, byte 0 in [7:0]; held until the next packet
//   data_valid   one-cycle pulse when a packet has been checked
//   crc_ok       with data_valid: length 80 and CRC residual correct
//   crc_err      with data_valid: length or CRC wrong
//   unstuff_err  with data_valid: a stuff position carried a 1
//
// Build option: define RX_STUFF_ERR_EN to flag a 1 in a stuff-bit position.
// Without it, stuff bits are dropped regardless of value and unstuff_err is 0.

module data_rx_unstuff (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_bit,
  input  logic        dpdm_sending,
  input  logic        load_data,
  output logic [63:0] data_out,
  output logic        data_valid,
  output logic        crc_ok,
  output logic        crc_err,
  output logic        unstuff_err
);

  typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;

  state_t      state, state_next;

  logic        prev_level;
  logic [79:0] shreg, shreg_next;
  logic [15:0] crc, crc_next;
  logic [6:0]  bit_cnt, bit_cnt_next;
  logic [2:0]  ones_cnt, ones_cnt_next;
  logic        stuff_err, stuff_err_next;

  logic        dec_bit;
  logic        start;
  logic        take;
  logic        crc_fb;
  logic        pkt_good;
  logic [15:0] crc_base;
  logic [6:0]  bit_cnt_base;
  logic [2:0]  ones_base;
  logic        stuff_err_base;

  assign dec_bit = (in_bit == prev_level);
  assign start   = (state == IDLE) && dpdm_sending;
  // The bit seen on the IDLE->RECV cycle is the first payload bit; it is
  // processed against freshly cleared counters. load_data wins in RECV.
  assign take    = start || ((state == RECV) && dpdm_sending && !load_data);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dpdm_sending) state_next = RECV;
      RECV:    if (load_data)    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  assign pkt_good = (bit_cnt == 7'd80) && (crc == 16'h800D) && !stuff_err;

  always_comb begin
    data_valid  = 1'b0;
    crc_ok      = 1'b0;
    crc_err     = 1'b0;
    unstuff_err = 1'b0;
    if (state == DONE) begin
      data_valid = 1'b1;
      crc_ok     = pkt_good;
      crc_err    = !pkt_good;
`ifdef RX_STUFF_ERR_EN
      unstuff_err = stuff_err;
`else
      unstuff_err = 1'b0;
`endif
    end
  end

  // ---------------- datapath: next values ----------------
  always_comb begin
    crc_base       = start ? 16'hFFFF : crc;
    bit_cnt_base   = start ? '0 : bit_cnt;
    ones_base      = start ? '0 : ones_cnt;
    stuff_err_base = start ? 1'b0 : stuff_err;

    shreg_next     = shreg;
    crc_next       = crc;
    bit_cnt_next   = bit_cnt;
    ones_cnt_next  = ones_cnt;
    stuff_err_next = stuff_err;
    crc_fb         = crc_base[15] ^ dec_bit;

    if (take) begin
      crc_next       = crc_base;
      bit_cnt_next   = bit_cnt_base;
      stuff_err_next = stuff_err_base;
      if (ones_base == 3'd6) begin
        // Stuff bit: dropped, only resets the run of ones.
        ones_cnt_next = '0;
`ifdef RX_STUFF_ERR_EN
        stuff_err_next = stuff_err_base | dec_bit;
`endif
      end else begin
        shreg_next    = {dec_bit, shreg[79:1]};
        // Left-shifting register fed in wire order; residual 0x800D.
        crc_next      = {crc_base[14:0], 1'b0} ^ (crc_fb ? 16'h8005 : 16'h0000);
        bit_cnt_next  = (bit_cnt_base == 7'd81) ? 7'd81 : bit_cnt_base + 7'd1;
        ones_cnt_next = dec_bit ? ones_base + 3'd1 : '0;
      end
    end
  end

  // ---------------- datapath: registers ----------------
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_level <= 1'b1;
      shreg      <= '0;
      crc        <= 16'hFFFF;
      bit_cnt    <= '0;
      ones_cnt   <= '0;
      stuff_err  <= 1'b0;
      data_out   <= '0;
    end else begin
      if (state != DONE) prev_level <= in_bit;
      shreg     <= shreg_next;
      crc       <= crc_next;
      bit_cnt   <= bit_cnt_next;
      ones_cnt  <= ones_cnt_next;
      stuff_err <= stuff_err_next;
      // Loaded on entry to DONE so it is valid alongside data_valid.
      if ((state == RECV) && load_data) data_out <= shreg[63:0];
    end
  end

endmodule

// File: tb/tb_data_rx_unstuff.sv
// Testbench for data_rx_unstuff: table of packets (payload, corruption,
// length, forced stuff value) with expected flags, plus hand-written
// sequences for reset state, load_data in IDLE, and mid-packet reset.

module tb_data_rx_unstuff;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_bit;
  logic        dpdm_sending;
  logic        load_data;
  logic [63:0] data_out;
  logic        data_valid;
  logic        crc_ok;
  logic        crc_err;
  logic        unstuff_err;

  int checks = 0;
  int errors = 0;
  logic level = 1'b1;

  logic kept_q[$];
  logic line_q[$];

  data_rx_unstuff dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_bit       (in_bit),
    .dpdm_sending (dpdm_sending),
    .load_data    (load_data),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .crc_ok       (crc_ok),
    .crc_err      (crc_err),
    .unstuff_err  (unstuff_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [63:0] payload;
    int          flip;        // payload bit to invert after CRC, -1 = none
    int unsigned nkept;       // 72, 80 or 88
    logic        force_stuff; // first stuff bit sent as 1
    int          pause_at;    // line index to insert 3 idle cycles, -1 = none
    logic        exp_ok;
    logic        exp_unstuff;
    logic        chk_data;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reflected CRC-16/USB over nbytes of d (byte 0 in [7:0]); returns the
  // transmitted (inverted) value.
  function automatic logic [15:0] crc16_usb(input logic [127:0] d, input int unsigned nbytes);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int unsigned i = 0; i < nbytes * 8; i++) begin
      fb = c[0] ^ d[i];
      c  = c >> 1;
      if (fb) c = c ^ 16'hA001;
    end
    return ~c;
  endfunction

  task automatic build(input vec_t v);
    logic [15:0] crc;
    int ones;
    logic forced;
    crc = crc16_usb({64'h0, v.payload}, 8);
    kept_q.delete();
    line_q.delete();
    for (int i = 0; i < 64; i++) kept_q.push_back(v.payload[i]);
    for (int i = 0; i < 16; i++) kept_q.push_back(crc[i]);
    if (v.flip >= 0) kept_q[v.flip] = ~kept_q[v.flip];
    while (kept_q.size() > v.nkept) void'(kept_q.pop_back());
    while (kept_q.size() < v.nkept) kept_q.push_back(1'b0);
    ones = 0;
    forced = 1'b0;
    foreach (kept_q[i]) begin
      line_q.push_back(kept_q[i]);
      ones = kept_q[i] ? ones + 1 : 0;
      if (ones == 6) begin
        line_q.push_back(v.force_stuff && !forced);
        if (v.force_stuff) forced = 1'b1;
        ones = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      dpdm_sending = 1'b0;
      load_data    = 1'b0;
      in_bit       = level;
      @(posedge clock); #1;
    end
  endtask

  // Sends line_q[0 .. count-1] NRZI encoded.
  task automatic send_line(input int count, input int pause_at);
    for (int i = 0; i < count; i++) begin
      if (i == pause_at) idle(3);
      if (!line_q[i]) level = ~level;
      in_bit       = level;
      dpdm_sending = 1'b1;
      @(posedge clock); #1;
    end
    dpdm_sending = 1'b0;
  endtask

  task automatic eop();
    load_data    = 1'b1;
    dpdm_sending = 1'b0;
    in_bit       = level;
    @(posedge clock); #1;
    load_data = 1'b0;
  endtask

  initial begin
    logic all_quiet;
    logic [63:0] held;

    vecs[0] = '{"good_0123",   64'h0123_4567_89AB_CDEF, -1, 80, 1'b0, -1, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{"flip_bit",    64'h0123_4567_89AB_CDEF,  5, 80, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{"all_ones",    64'hFFFF_FFFF_FFFF_FFFF, -1, 80, 1'b0, -1, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{"len72",       64'h0123_4567_89AB_CDEF, -1, 72, 1'b0, -1, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{"len88",       64'h0123_4567_89AB_CDEF, -1, 88, 1'b0, -1, 1'b0, 1'b0, 1'b0};
`ifdef RX_STUFF_ERR_EN
    vecs[5] = '{"stuff_one",   64'hFFFF_FFFF_FFFF_FFFF, -1, 80, 1'b1, -1, 1'b0, 1'b1, 1'b0};
`else
    vecs[5] = '{"stuff_one",   64'hFFFF_FFFF_FFFF_FFFF, -1, 80, 1'b1, -1, 1'b1, 1'b0, 1'b1};
`endif
    vecs[6] = '{"zero_pause",  64'h0000_0000_0000_0000, -1, 80, 1'b0, 20, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{"a5_pattern",  64'hA5A5_3C3C_0F0F_7E81, -1, 80, 1'b0, -1, 1'b1, 1'b0, 1'b1};

    check("model_crc_check", crc16_usb({56'h0, 72'h39_38_37_36_35_34_33_32_31}, 9), 16'hB4C8);

    // Reset state
    reset_n = 1'b0; in_bit = 1'b1; dpdm_sending = 1'b0; load_data = 1'b0;
    #12;
    check("rst_data_out",    data_out,    64'h0);
    check("rst_data_valid",  data_valid,  1'b0);
    check("rst_crc_ok",      crc_ok,      1'b0);
    check("rst_crc_err",     crc_err,     1'b0);
    check("rst_unstuff_err", unstuff_err, 1'b0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    idle(3);

    // load_data in IDLE is ignored
    eop();
    check("idle_eop_no_pulse", data_valid, 1'b0);
    idle(2);
    check("idle_eop_no_pulse2", data_valid, 1'b0);

    foreach (vecs[k]) begin
      build(vecs[k]);
      send_line(line_q.size(), vecs[k].pause_at);
      check({vecs[k].name, "_pre_eop_valid"}, data_valid, 1'b0);
      eop();
      check({vecs[k].name, "_valid"},   data_valid,  1'b1);
      check({vecs[k].name, "_crc_ok"},  crc_ok,      vecs[k].exp_ok);
      check({vecs[k].name, "_crc_err"}, crc_err,     !vecs[k].exp_ok);
      check({vecs[k].name, "_unstuff"}, unstuff_err, vecs[k].exp_unstuff);
      if (vecs[k].chk_data) check({vecs[k].name, "_data"}, data_out, vecs[k].payload);
      held = data_out;
      idle(1);
      check({vecs[k].name, "_pulse_one_cycle"}, data_valid, 1'b0);
      check({vecs[k].name, "_data_hold"}, data_out, held);
      idle(3);
    end

    // Reset mid-packet: abort with no pulse, next packet normal
    build(vecs[0]);
    send_line(40, -1);
    reset_n = 1'b0;
    #2;
    check("abort_rst_data_out", data_out, 64'h0);
    check("abort_rst_valid", data_valid, 1'b0);
    idle(2);
    reset_n = 1'b1;
    all_quiet = 1'b1;
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (data_valid) all_quiet = 1'b0;
    end
    check("abort_no_pulse", all_quiet, 1'b1);
    build(vecs[0]);
    send_line(line_q.size(), -1);
    eop();
    check("after_abort_valid",  data_valid, 1'b1);
    check("after_abort_crc_ok", crc_ok,     1'b1);
    check("after_abort_data",   data_out,   64'h0123_4567_89AB_CDEF);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
